// File: rtl/case_scan_controller.sv
// case_scan_controller: steps a select through every entry of a combinational
// lookup, waits SETTLE cycles per entry, captures the word and streams it out
// on a valid/ready port tagged with its index.
// Optional: define CASE_SCAN_CHECK_EN to add an XOR checksum output.
module case_scan_controller #(
  parameter int SEL_W    = 2,
  parameter int ELEM_W   = 4,
  parameter int NUM_ELEM = 3,
  parameter int SETTLE   = 1,
  localparam int DATA_W  = ELEM_W * NUM_ELEM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_index,
  output logic              busy,
  output logic              done
`ifdef CASE_SCAN_CHECK_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // one spare bit so the all-ones entry is recognised without wrapping to 0
  localparam int IDX_W = SEL_W + 1;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << SEL_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_OUT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_index_q, out_index_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef CASE_SCAN_CHECK_EN
  logic [DATA_W-1:0] cks_q, cks_d;
`endif

  // next-state and registered-output decode; abort outranks every other event
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    settle_d    = settle_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef CASE_SCAN_CHECK_EN
    cks_d       = cks_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_DRIVE;
          idx_d    = '0;
          sel_d    = '0;
          settle_d = CNT_W'(SETTLE);
          busy_d   = 1'b1;
`ifdef CASE_SCAN_CHECK_EN
          cks_d    = '0;
`endif
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
        end else if (settle_q != '0) begin
          settle_d = settle_q - CNT_W'(1);
        end else begin
          state_d     = S_OUT;
          out_data_d  = data_i;
          out_index_d = idx_q[SEL_W-1:0];
          out_valid_d = 1'b1;
`ifdef CASE_SCAN_CHECK_EN
          cks_d       = cks_q ^ data_i;
`endif
        end
      end
      S_OUT: begin
        if (abort) begin
          // a beat accepted in this same cycle still counts as delivered
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = S_DRIVE;
            idx_d    = idx_q + IDX_W'(1);
            sel_d    = idx_d[SEL_W-1:0];
            settle_d = CNT_W'(SETTLE);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      sel_q       <= '0;
      settle_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CASE_SCAN_CHECK_EN
      cks_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      settle_q    <= settle_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CASE_SCAN_CHECK_EN
      cks_q       <= cks_d;
`endif
    end
  end

  assign sel_o     = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CASE_SCAN_CHECK_EN
  assign checksum  = cks_q;
`endif

endmodule
